// File: rtl/ecdsa_pkg.sv
// Shared types and constants for the ecdsa DMA responder.
package ecdsa_pkg;

    localparam int unsigned DATA_W     = 381;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BEAT_BYTES = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dma_state_e;

    // Captured request: direction, address validity and byte address.
    typedef struct packed {
        logic              write;
        logic              bad;
        logic [ADDR_W-1:0] addr;
    } dma_req_t;

    // Address is unusable when it is not beat aligned or its line lies beyond the memory.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       line_shift,
                                      input int unsigned       depth);
        logic [ADDR_W-1:0] mask;
        mask = (ADDR_W'(1) << line_shift) - ADDR_W'(1);
        return ((addr >> line_shift) >= ADDR_W'(depth)) || ((addr & mask) != '0);
    endfunction

endpackage

// File: rtl/dma_responder_if.sv
// DMA request/response bundle between the ecdsa core (master) and the responder (slave).
interface dma_responder_if;
    import ecdsa_pkg::*;

    logic [ADDR_W-1:0] dma_rx_address;
    logic              dma_rx_start;
    logic [DATA_W-1:0] dma_rx_data;
    logic [ADDR_W-1:0] dma_tx_address;
    logic              dma_tx_start;
    logic [DATA_W-1:0] dma_tx_data;
    logic              dma_done;
    logic              dma_idle;
    logic              dma_error;

    modport master (
        output dma_rx_address, dma_rx_start, dma_tx_address, dma_tx_start, dma_tx_data,
        input  dma_rx_data, dma_done, dma_idle, dma_error
    );

    modport slave (
        input  dma_rx_address, dma_rx_start, dma_tx_address, dma_tx_start, dma_tx_data,
        output dma_rx_data, dma_done, dma_idle, dma_error
    );
endinterface

// File: rtl/dma_line_mem.sv
// Line memory: registered DMA write, host write (DMA wins on same line), async reads.
module dma_line_mem
    import ecdsa_pkg::*;
#(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              dma_we_i,
    input  logic [IDX_W-1:0]  dma_idx_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic [DATA_W-1:0] dma_rdata_o,
    input  logic              host_we_i,
    input  logic [IDX_W-1:0]  host_idx_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic [DATA_W-1:0] host_rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Host write is suppressed only when a DMA write targets the same line on this edge.
    always_ff @(posedge clk) begin
        if (host_we_i && !(dma_we_i && (host_idx_i == dma_idx_i))) begin
            mem_q[host_idx_i] <= host_wdata_i;
        end
        if (dma_we_i) begin
            mem_q[dma_idx_i] <= dma_wdata_i;
        end
    end

    assign dma_rdata_o  = mem_q[dma_idx_i];
    assign host_rdata_o = mem_q[host_idx_i];

endmodule

// File: rtl/dma_responder.sv
// Memory-side DMA responder: accepts one rx/tx request, waits LATENCY cycles, completes with a done pulse.
module dma_responder
    import ecdsa_pkg::*;
#(
    parameter  int unsigned DEPTH      = 64,
    parameter  int unsigned LATENCY    = 8,
    parameter  int unsigned LINE_SHIFT = $clog2(BEAT_BYTES),
    localparam int unsigned IDX_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    dma_responder_if.slave    dma,
    input  logic              host_we,
    input  logic [IDX_W-1:0]  host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata
);

    dma_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dma_req_t          req_q, req_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              idle_q, idle_d;
    logic              mem_we_c;
    logic [DATA_W-1:0] mem_rdata_c;
    logic [IDX_W-1:0]  line_idx_c;
    logic              any_start_c;
    logic [ADDR_W-1:0] acc_addr_c;

    assign line_idx_c  = IDX_W'(req_q.addr >> LINE_SHIFT);
    assign any_start_c = dma.dma_rx_start || dma.dma_tx_start;
    assign acc_addr_c  = dma.dma_tx_start ? dma.dma_tx_address : dma.dma_rx_address;

    dma_line_mem #(.DEPTH(DEPTH)) u_mem (
        .clk          (clk),
        .dma_we_i     (mem_we_c),
        .dma_idx_i    (line_idx_c),
        .dma_wdata_i  (wdata_q),
        .dma_rdata_o  (mem_rdata_c),
        .host_we_i    (host_we),
        .host_idx_i   (host_addr),
        .host_wdata_i (host_wdata),
        .host_rdata_o (host_rdata)
    );

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            wdata_q   <= '0;
            rx_data_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            wdata_q   <= wdata_d;
            rx_data_q <= rx_data_d;
            err_q     <= err_d;
            done_q    <= done_d;
            idle_q    <= idle_d;
        end
    end

    // Next-state: accept, count down latency, commit the line on entry to DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        wdata_d   = wdata_q;
        rx_data_d = rx_data_q;
        err_d     = err_q;
        mem_we_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (dma.dma_rx_start && dma.dma_tx_start) begin
                    err_d = 1'b1;
                end else if (any_start_c) begin
                    req_d.write = dma.dma_tx_start;
                    req_d.addr  = acc_addr_c;
                    req_d.bad   = addr_bad(acc_addr_c, LINE_SHIFT, DEPTH);
                    if (req_d.bad) begin
                        err_d = 1'b1;
                    end
                    if (dma.dma_tx_start) begin
                        wdata_d = dma.dma_tx_data;
                    end
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (any_start_c) begin
                    err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (req_q.write) begin
                        mem_we_c = !req_q.bad;
                    end else begin
                        rx_data_d = req_q.bad ? '0 : mem_rdata_c;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (any_start_c) begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
        idle_d = (state_d == ST_IDLE);
    end

    assign dma.dma_rx_data = rx_data_q;
    assign dma.dma_done    = done_q;
    assign dma.dma_idle    = idle_q;
    assign dma.dma_error   = err_q;

endmodule

// File: tb/tb_dma_responder.sv
// Randomized directed bench for dma_responder against a line-array reference model.
module tb_dma_responder;
    import ecdsa_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 8;
    localparam int unsigned LS    = 7;

    logic              clk;
    logic              resetn;
    logic              host_we;
    logic [5:0]        host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;

    dma_responder_if dif ();

    dma_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .LINE_SHIFT(LS)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .dma        (dif.slave),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] last_rx;
    logic              err_exp;
    int                tests;
    int                fails;

    function automatic logic [DATA_W-1:0] rnd381();
        logic [383:0] t;
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom();
        return t[DATA_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hwrite(input int unsigned idx, input logic [DATA_W-1:0] d);
        host_we    = 1'b1;
        host_addr  = 6'(idx);
        host_wdata = d;
        cyc();
        host_we    = 1'b0;
        model[idx] = d;
    endtask

    task automatic hchk(input string tag, input int unsigned idx);
        host_addr = 6'(idx);
        #1;
        chk(tag, host_rdata, model[idx]);
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        cyc();
        cyc();
        chk("rst_idle", 381'(dif.dma_idle), 381'(1));
        chk("rst_done", 381'(dif.dma_done), 381'(0));
        chk("rst_error", 381'(dif.dma_error), 381'(0));
        chk("rst_rxdata", dif.dma_rx_data, '0);
        resetn  = 1'b0;
        err_exp = 1'b0;
        last_rx = '0;
    endtask

    // One complete transfer, optionally with host writes to other lines while busy.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [DATA_W-1:0] wd, input bit noise);
        int          k;
        int unsigned idx;
        int unsigned h;
        bit          bad;
        idx = addr / (32'd1 << LS);
        bad = (idx >= DEPTH) || ((addr % (32'd1 << LS)) != 0);
        if (wr) begin
            dif.dma_tx_start   = 1'b1;
            dif.dma_tx_address = addr;
            dif.dma_tx_data    = wd;
        end else begin
            dif.dma_rx_start   = 1'b1;
            dif.dma_rx_address = addr;
        end
        cyc();
        dif.dma_tx_start = 1'b0;
        dif.dma_rx_start = 1'b0;
        k = 1;
        if (bad) err_exp = 1'b1;
        chk("idle_drop", 381'(dif.dma_idle), 381'(0));
        while (dif.dma_done !== 1'b1 && k < 40) begin
            if (noise && $urandom_range(2) == 0) begin
                h = $urandom_range(DEPTH - 1);
                if (h != idx) begin
                    host_we    = 1'b1;
                    host_addr  = 6'(h);
                    host_wdata = rnd381();
                    model[h]   = host_wdata;
                end
            end
            cyc();
            host_we = 1'b0;
            k++;
        end
        chk("done_latency", 381'(k), 381'(LAT + 1));
        if (!wr) last_rx = bad ? '0 : model[idx];
        chk("rx_data", dif.dma_rx_data, last_rx);
        if (wr && !bad) model[idx] = wd;
        chk("error", 381'(dif.dma_error), 381'(err_exp));
        cyc();
        chk("done_clear", 381'(dif.dma_done), 381'(0));
        chk("idle_back", 381'(dif.dma_idle), 381'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] tbl;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        int                k;
        tests = 0;
        fails = 0;
        err_exp = 1'b0;
        last_rx = '0;
        resetn = 1'b1;
        host_we = 1'b0;
        host_addr = '0;
        host_wdata = '0;
        dif.dma_rx_start = 1'b0;
        dif.dma_tx_start = 1'b0;
        dif.dma_rx_address = '0;
        dif.dma_tx_address = '0;
        dif.dma_tx_data = '0;
        #2;
        do_reset();

        for (int i = 0; i < DEPTH; i++) hwrite(i, rnd381());

        // Single read of line 3
        hwrite(3, 381'h1234);
        xfer(1'b0, 32'h180, '0, 1'b0);

        // Write all-ones then read back
        xfer(1'b1, 32'h100, '1, 1'b0);
        hchk("host_readback", 2);
        xfer(1'b0, 32'h100, '0, 1'b0);

        // Argument table with three operand pointers
        tbl = '0;
        tbl[31:0]  = 32'h80;
        tbl[63:32] = 32'h100;
        tbl[95:64] = 32'h180;
        hwrite(0, tbl);
        for (int i = 1; i <= 3; i++) hwrite(i, rnd381());
        xfer(1'b0, 32'h0, '0, 1'b0);
        for (int i = 0; i < 3; i++) xfer(1'b0, tbl[i*32 +: 32], '0, 1'b1);

        // Random aligned traffic with host activity on other lines
        for (int n = 0; n < 30; n++) begin
            xfer(1'(($urandom_range(1))), 32'($urandom_range(DEPTH - 1)) << LS, rnd381(), 1'b1);
            repeat ($urandom_range(3)) cyc();
        end
        hchk("host_random", $urandom_range(DEPTH - 1));

        // Bad addresses: misaligned read, out-of-range read, misaligned write
        xfer(1'b0, 32'h2001, '0, 1'b0);
        xfer(1'b0, 32'h2000, '0, 1'b0);
        xfer(1'b1, 32'h181, rnd381(), 1'b0);
        hchk("bad_write_discard", 3);

        // Simultaneous rx and tx start
        do_reset();
        dif.dma_rx_start = 1'b1;
        dif.dma_rx_address = 32'h80;
        dif.dma_tx_start = 1'b1;
        dif.dma_tx_address = 32'h100;
        dif.dma_tx_data = rnd381();
        cyc();
        dif.dma_rx_start = 1'b0;
        dif.dma_tx_start = 1'b0;
        err_exp = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            chk("both_no_done", 381'(dif.dma_done), 381'(0));
            chk("both_idle", 381'(dif.dma_idle), 381'(1));
            cyc();
        end
        chk("both_error", 381'(dif.dma_error), 381'(1));
        hchk("both_no_write", 2);

        // Start while busy is ignored
        do_reset();
        dif.dma_rx_start = 1'b1;
        dif.dma_rx_address = 32'h100;
        cyc();
        dif.dma_rx_start = 1'b0;
        k = 1;
        while (dif.dma_done !== 1'b1 && k < 40) begin
            if (k == 3) begin
                dif.dma_tx_start = 1'b1;
                dif.dma_tx_address = 32'h380;
                dif.dma_tx_data = rnd381();
            end
            cyc();
            dif.dma_tx_start = 1'b0;
            k++;
        end
        err_exp = 1'b1;
        chk("busy_latency", 381'(k), 381'(LAT + 1));
        chk("busy_rxdata", dif.dma_rx_data, model[2]);
        chk("busy_error", 381'(dif.dma_error), 381'(1));
        cyc();
        chk("busy_idle_back", 381'(dif.dma_idle), 381'(1));
        hchk("busy_no_write", 7);

        // Reset mid-transfer to line 5
        d0 = ~model[5];
        dif.dma_tx_start = 1'b1;
        dif.dma_tx_address = 32'h280;
        dif.dma_tx_data = d0;
        cyc();
        dif.dma_tx_start = 1'b0;
        repeat (3) cyc();
        resetn = 1'b1;
        #1;
        chk("abort_idle", 381'(dif.dma_idle), 381'(1));
        chk("abort_done", 381'(dif.dma_done), 381'(0));
        chk("abort_error", 381'(dif.dma_error), 381'(0));
        cyc();
        cyc();
        resetn = 1'b0;
        err_exp = 1'b0;
        last_rx = '0;
        for (int i = 0; i < LAT + 3; i++) begin
            chk("abort_no_done", 381'(dif.dma_done), 381'(0));
            cyc();
        end
        hchk("abort_line5", 5);

        // Host write colliding with the DMA commit to line 7
        d0 = rnd381();
        d1 = rnd381();
        dif.dma_tx_start = 1'b1;
        dif.dma_tx_address = 32'h380;
        dif.dma_tx_data = d0;
        cyc();
        dif.dma_tx_start = 1'b0;
        k = 1;
        while (dif.dma_done !== 1'b1 && k < 40) begin
            if (k == LAT) begin
                host_we = 1'b1;
                host_addr = 6'd7;
                host_wdata = d1;
            end
            cyc();
            host_we = 1'b0;
            k++;
        end
        model[7] = d0;
        chk("coll_latency", 381'(k), 381'(LAT + 1));
        hchk("coll_line7", 7);
        chk("coll_error", 381'(dif.dma_error), 381'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
